// File: rtl/ch0re_types.sv
// Shared types for the iterative multiply/divide sequencer.
// Operation encodings, FSM states and small operation-class decoders.
package ch0re_types;

   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } muldiv_op_e;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_e;

   function automatic logic op_is_div(muldiv_op_e op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic op_is_rem(muldiv_op_e op);
      return op inside {MD_REM, MD_REMU};
   endfunction

   function automatic logic op_is_mulh(muldiv_op_e op);
      return op inside {MD_MULH, MD_MULHSU, MD_MULHU};
   endfunction

   // Result taken from the upper register (product high half or remainder).
   function automatic logic op_res_hi(muldiv_op_e op);
      return op inside {MD_MULH, MD_MULHSU, MD_MULHU, MD_REM, MD_REMU};
   endfunction

   function automatic logic op_s1_signed(muldiv_op_e op);
      return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic op_s2_signed(muldiv_op_e op);
      return op inside {MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the muldiv sequencer.
interface muldiv_seq_if
   import ch0re_types::*;
#(
   parameter int unsigned WIDTH = 64
) ();

   logic             i_valid;
   logic             o_ready;
   muldiv_op_e       i_op;
   logic [WIDTH-1:0] i_s1;
   logic [WIDTH-1:0] i_s2;
   logic             i_kill;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_res;
   logic             o_busy;

   modport slave (
      input  i_valid, i_op, i_s1, i_s2, i_kill, i_ready,
      output o_ready, o_valid, o_res, o_busy
   );

   modport master (
      output i_valid, i_op, i_s1, i_s2, i_kill, i_ready,
      input  o_ready, o_valid, o_res, o_busy
   );

endinterface

// File: rtl/muldiv_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the multiply, divide and negate steps.
// o_carry is the carry out; on subtract it is set when i_a >= i_b (unsigned).
module muldiv_addsub #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH:0] i_a,
   input  logic [WIDTH:0] i_b,
   input  logic           i_sub,
   output logic [WIDTH:0] o_sum,
   output logic           o_carry
);

   logic [WIDTH:0] b_eff;

   always_comb begin
      b_eff              = i_sub ? ~i_b : i_b;
      {o_carry, o_sum}   = {1'b0, i_a} + {1'b0, b_eff} + {{(WIDTH + 1){1'b0}}, i_sub};
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiply, restoring divide,
// one bit per cycle on a single shared add/subtract unit.
module muldiv_seq
   import ch0re_types::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   muldiv_seq_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

   muldiv_state_e    state_q, state_d;
   muldiv_op_e       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d, dsr_q, dsr_d;
   logic [WIDTH-1:0] sft_q, sft_d, res_q, res_d;
   logic             neg_q, neg_d;

   logic             s1_neg, s2_neg, div_zero, div_ovf, fix_inc;
   logic [WIDTH-1:0] s1_mag, s2_mag, spec_res, fix_sel;
   logic [WIDTH:0]   as_a, as_b, as_sum;
   logic             as_sub, as_carry;

   always_comb begin
      s1_neg   = op_s1_signed(bus.i_op) & bus.i_s1[WIDTH-1];
      s2_neg   = op_s2_signed(bus.i_op) & bus.i_s2[WIDTH-1];
      s1_mag   = s1_neg ? (~bus.i_s1 + WIDTH'(1)) : bus.i_s1;
      s2_mag   = s2_neg ? (~bus.i_s2 + WIDTH'(1)) : bus.i_s2;
      div_zero = op_is_div(bus.i_op) && (bus.i_s2 == '0);
      div_ovf  = (bus.i_op inside {MD_DIV, MD_REM}) && (bus.i_s1 == MinNeg) && (&bus.i_s2);
      if (op_is_rem(bus.i_op)) spec_res = div_zero ? bus.i_s1 : '0;
      else                     spec_res = div_zero ? '1 : bus.i_s1;
      fix_sel  = op_res_hi(op_q) ? acc_q[WIDTH-1:0] : sft_q;
      // High half of a negated product only takes the +1 when the low half is zero.
      fix_inc  = op_is_mulh(op_q) ? (sft_q == '0) : 1'b1;
   end

   always_comb begin
      as_a   = {1'b0, ~fix_sel};
      as_b   = {{WIDTH{1'b0}}, fix_inc};
      as_sub = 1'b0;
      if (state_q == CALC) begin
         if (op_is_div(op_q)) begin
            as_a   = {acc_q[WIDTH-1:0], sft_q[WIDTH-1]};
            as_b   = dsr_q;
            as_sub = 1'b1;
         end else begin
            as_a   = acc_q;
            as_b   = sft_q[0] ? dsr_q : '0;
         end
      end
   end

   muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_a     (as_a),
      .i_b     (as_b),
      .i_sub   (as_sub),
      .o_sum   (as_sum),
      .o_carry (as_carry)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sft_d   = sft_q;
      dsr_d   = dsr_q;
      neg_d   = neg_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_valid && !bus.i_kill) begin
               op_d  = bus.i_op;
               cnt_d = '0;
               acc_d = '0;
               if (op_is_div(bus.i_op)) begin
                  sft_d = s1_mag;
                  dsr_d = {1'b0, s2_mag};
                  neg_d = op_is_rem(bus.i_op) ? s1_neg : (s1_neg ^ s2_neg);
               end else begin
                  sft_d = s2_mag;
                  dsr_d = {1'b0, s1_mag};
                  neg_d = s1_neg ^ s2_neg;
               end
               if (div_zero || div_ovf) begin
                  res_d   = spec_res;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (bus.i_kill) begin
               state_d = IDLE;
            end else begin
               if (op_is_div(op_q)) begin
                  acc_d = as_carry ? as_sum : {acc_q[WIDTH-1:0], sft_q[WIDTH-1]};
                  sft_d = {sft_q[WIDTH-2:0], as_carry};
               end else begin
                  acc_d = {1'b0, as_sum[WIDTH:1]};
                  sft_d = {as_sum[0], sft_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
         end
         FIX: begin
            if (bus.i_kill) begin
               state_d = IDLE;
            end else begin
               res_d   = neg_q ? as_sum[WIDTH-1:0] : fix_sel;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.i_kill || bus.i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         op_q    <= MD_MUL;
         cnt_q   <= '0;
         acc_q   <= '0;
         sft_q   <= '0;
         dsr_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sft_q   <= sft_d;
         dsr_q   <= dsr_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign bus.o_ready = (state_q == IDLE);
   assign bus.o_valid = (state_q == DONE);
   assign bus.o_busy  = (state_q != IDLE);
   assign bus.o_res   = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=64).
module tb_muldiv_seq;
   import ch0re_types::*;

   localparam int unsigned W = 64;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   muldiv_seq_if #(.WIDTH(W)) bus ();

   muldiv_seq #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a request and return just after the accept edge.
   task automatic start(input muldiv_op_e op, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      bus.i_op    = op;
      bus.i_s1    = a;
      bus.i_s2    = b;
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_op    = MD_REMU;
      bus.i_s1    = 64'hDEAD_BEEF_0BAD_F00D;
      bus.i_s2    = 64'h1234_5678_9ABC_DEF0;
   endtask

   // lat = edges after the accept edge until o_valid is seen (bounded).
   task automatic wait_valid(output int lat, output logic [63:0] res);
      lat = 0;
      while (!bus.o_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.o_res;
   endtask

   task automatic drain();
      @(negedge clk);
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
   endtask

   task automatic test_reset();
      total += 4;
      if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.o_valid); end
      if (bus.o_busy  !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
      if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.o_ready); end
      if (bus.o_res   !== '0)   begin bad++; $display("FAIL rst_res: got %h want 0", bus.o_res); end
   endtask

   task automatic test_mul();
      int lat;
      logic [63:0] r;
      start(MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      total += 2;
      if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0) begin
         bad++; $display("FAIL mul_busy: got busy=%b ready=%b want 1/0", bus.o_busy, bus.o_ready);
      end
      wait_valid(lat, r);
      if (lat !== 65) begin bad++; $display("FAIL mul_latency: got %0d want 65", lat); end
      total++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         bad++; $display("FAIL mul_res: got %h want ffffffffffffffeb", r);
      end
      drain();
   endtask

   task automatic test_mulh();
      int lat;
      logic [63:0] r;
      start(MD_MULHU, ONES, 64'd2);
      wait_valid(lat, r);
      total++;
      if (r !== 64'd1) begin bad++; $display("FAIL mulhu: got %h want 1", r); end
      drain();
      start(MD_MULH, ONES, ONES);
      wait_valid(lat, r);
      total++;
      if (r !== 64'd0) begin bad++; $display("FAIL mulh: got %h want 0", r); end
      drain();
      start(MD_MULHSU, ONES, 64'd2);
      wait_valid(lat, r);
      total++;
      if (r !== ONES) begin bad++; $display("FAIL mulhsu: got %h want %h", r, ONES); end
      drain();
   endtask

   task automatic test_div();
      int lat;
      logic [63:0] r;
      start(MD_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      wait_valid(lat, r);
      total += 2;
      if (lat !== 65) begin bad++; $display("FAIL div_latency: got %0d want 65", lat); end
      if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         bad++; $display("FAIL div: got %h want fffffffffffffffd", r);
      end
      drain();
      start(MD_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      wait_valid(lat, r);
      total++;
      if (r !== ONES) begin bad++; $display("FAIL rem: got %h want %h", r, ONES); end
      drain();
      start(MD_DIVU, 64'd100, 64'd7);
      wait_valid(lat, r);
      total++;
      if (r !== 64'd14) begin bad++; $display("FAIL divu: got %h want e", r); end
      drain();
      start(MD_REMU, 64'd100, 64'd7);
      wait_valid(lat, r);
      total++;
      if (r !== 64'd2) begin bad++; $display("FAIL remu: got %h want 2", r); end
      drain();
   endtask

   task automatic test_special();
      int lat;
      logic [63:0] r;
      start(MD_DIVU, 64'd5, 64'd0);
      wait_valid(lat, r);
      total += 2;
      if (lat !== 0) begin bad++; $display("FAIL divu0_latency: got %0d want 0", lat); end
      if (r !== ONES) begin bad++; $display("FAIL divu0: got %h want %h", r, ONES); end
      drain();
      start(MD_REMU, 64'd5, 64'd0);
      wait_valid(lat, r);
      total += 2;
      if (lat !== 0) begin bad++; $display("FAIL remu0_latency: got %0d want 0", lat); end
      if (r !== 64'd5) begin bad++; $display("FAIL remu0: got %h want 5", r); end
      drain();
      start(MD_DIV, MINN, ONES);
      wait_valid(lat, r);
      total += 2;
      if (lat !== 0) begin bad++; $display("FAIL divovf_latency: got %0d want 0", lat); end
      if (r !== MINN) begin bad++; $display("FAIL divovf: got %h want %h", r, MINN); end
      drain();
      start(MD_REM, MINN, ONES);
      wait_valid(lat, r);
      total += 2;
      if (lat !== 0) begin bad++; $display("FAIL removf_latency: got %0d want 0", lat); end
      if (r !== 64'd0) begin bad++; $display("FAIL removf: got %h want 0", r); end
      drain();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [63:0] r;
      start(MD_DIVU, 64'd100, 64'd7);
      wait_valid(lat, r);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (bus.o_valid !== 1'b1 || bus.o_res !== 64'd14 || bus.o_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: got valid=%b res=%h ready=%b want 1/e/0",
                     i, bus.o_valid, bus.o_res, bus.o_ready);
         end
      end
      @(negedge clk);
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
      total++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", bus.o_ready, bus.o_valid);
      end
   endtask

   task automatic test_kill();
      int seen;
      start(MD_MUL, 64'd123, 64'd456);
      // Ten iterations done; the kill lands on iteration 10.
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.i_kill = 1'b1;
      @(posedge clk);
      #1;
      bus.i_kill = 1'b0;
      total++;
      if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
         bad++;
         $display("FAIL kill_idle: got ready=%b busy=%b valid=%b want 1/0/0",
                  bus.o_ready, bus.o_busy, bus.o_valid);
      end
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus.o_valid) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL kill_novalid: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_reset_mid();
      start(MD_MUL, 64'd99, 64'd77);
      repeat (20) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_res !== '0) begin
         bad++;
         $display("FAIL midrst: got busy=%b ready=%b valid=%b res=%h want 0/1/0/0",
                  bus.o_busy, bus.o_ready, bus.o_valid, bus.o_res);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_after_abort();
      int lat;
      logic [63:0] r;
      start(MD_MUL, 64'd3, 64'd4);
      wait_valid(lat, r);
      total += 2;
      if (lat !== 65) begin bad++; $display("FAIL post_latency: got %0d want 65", lat); end
      if (r !== 64'd12) begin bad++; $display("FAIL post_mul: got %h want c", r); end
      drain();
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_op    = MD_MUL;
      bus.i_s1    = '0;
      bus.i_s2    = '0;
      bus.i_kill  = 1'b0;
      bus.i_ready = 1'b0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_mul();
      test_mulh();
      test_div();
      test_special();
      test_backpressure();
      test_kill();
      test_reset_mid();
      test_after_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the RV64M multiply/divide group. It accepts one operation at a time over a valid/ready handshake.
- Multiplication is shift-add; division is restoring. Both run one bit per cycle on a single shared WIDTH+1-bit add/subtract unit.
- Sits beside the combinational ALU in the execute stage. The execute stage stalls on o_ready/o_valid.

Parameters:
- WIDTH, 64, operand/result width. Must be >= 2 and a power of two.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  request valid
- o_ready  output  1  sequencer can accept a request (state IDLE)
- i_op  input  muldiv_op_e  operation select
- i_s1  input  WIDTH  rs1 operand (multiplicand/dividend)
- i_s2  input  WIDTH  rs2 operand (multiplier/divisor)
- i_kill  input  1  pipeline flush; aborts any operation in flight
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_res  output  WIDTH  result
- o_busy  output  1  state != IDLE

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_valid=0, o_busy=0, o_ready=1, o_res=0; counter and internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept on an edge with i_valid & o_ready & !i_kill.
  - On accept, latch the op and store magnitudes of signed operands:
    - DIV/REM: both operands signed.
    - MULH: both operands signed.
    - MULHSU: only s1 signed.
  - Record the result sign:
    - quotient sign = s1 sign ^ s2 sign.
    - remainder sign = s1 sign.
    - product sign = XOR of the signed-operand signs.
  - Clear the counter and go to CALC.
- Special cases skip CALC and go directly to DONE on the accept edge, so o_valid is high the next cycle:
  - Divide by zero, i_s2==0 on DIV/DIVU/REM/REMU: quotient = all ones; remainder = i_s1.
  - Signed overflow, DIV/REM with i_s1 = 1<<(WIDTH-1) and i_s2 = all ones: quotient = i_s1; remainder = 0.
- CALC, one iteration per edge, counter 0..WIDTH-1:
  - Multiply: if multiplier LSB is set, add the multiplicand into the upper accumulator (WIDTH+1-bit carry). Then shift the {acc, multiplier} pair right by 1.
  - Divide: shift {rem, quot} left by 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quot LSB; otherwise restore.
  - At counter==WIDTH-1, go to FIX.
- FIX, one edge:
  - Select the result: MUL gives the low half; MULH* give the high half; DIV* give the quotient; REM* give the remainder.
  - Two's-complement negate per the recorded sign. For products, negate the full 2*WIDTH value before selecting the half.
  - Register o_res and go to DONE.
- DONE:
  - o_valid=1; o_res is held stable while i_ready=0.
  - When o_valid & i_ready, go to IDLE.
  - A new request is not accepted in the same cycle (o_ready=0 in DONE).
- Latency:
  - Normal: o_valid first high WIDTH+1 edges after the accept edge (65 for WIDTH=64).
  - Special cases: 1 edge.
- i_kill in any non-IDLE state: go to IDLE next edge, o_valid=0, result discarded.
- i_kill has priority over accept and over result consumption.
- Reset asserted mid-operation: immediate return to the reset values; no result is emitted.
- Inputs are ignored outside the accepting IDLE cycle.
- Arithmetic wraps modulo 2^WIDTH; magnitudes are WIDTH+1 bits internally so |most negative| is representable.

Decomposition:
- ch0re_types package:
  - muldiv_op_e enum: MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU.
  - muldiv_state_e enum: IDLE, CALC, FIX, DONE.
- Sub-module muldiv_addsub:
  - Combinational WIDTH+1-bit add/subtract with i_sub, producing sum and sign/carry.
  - Shared by both iteration types and by the FIX negation.

Test Plan:
- MD_MUL 7 × 0xFFFF_FFFF_FFFF_FFFD (−3) -> o_res 0xFFFF_FFFF_FFFF_FFEB; o_valid rises exactly 65 edges after accept.
- MD_MULHU all-ones × 2 -> 0x1; MD_MULH (−1)×(−1) -> 0x0; MD_MULHSU (−1)×2 -> all ones.
- MD_DIV −7/2 -> 0xFFFF_FFFF_FFFF_FFFD; MD_REM −7/2 -> all ones (−1); MD_DIVU 100/7 -> 14; MD_REMU 100/7 -> 2.
- MD_DIVU 5/0 -> all ones and MD_REMU 5/0 -> 5; MD_DIV 0x8000_0000_0000_0000 / −1 -> 0x8000_0000_0000_0000 and MD_REM of the same -> 0. All with latency 1 edge.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_res stable; o_ready=0 throughout; IDLE on the edge after i_ready=1.
- Abort: i_kill at CALC iteration 10 -> o_ready=1 next cycle, no o_valid. i_rst_n pulsed low mid-CALC -> outputs take reset values immediately. A following MD_MUL 3×4 -> 12 completes correctly.
